fixed_divide_seq: RTL

Sequential signed fixed-point divider with ready/valid handshakes on both sides, a selectable rounding mode, saturation, and divide-by-zero and overflow flags. It is the parametrised successor to the team's one-shot divider. It computes one quotient bit per cycle over a widened dividend with constant latency. It sits in the ray-intersection datapath, where it computes t = num/den and barycentric ratios, and a sideband tag lets callers match results to requests.

---
 rtl/fixed_divide_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fixed_divide_seq.sv
// Sequential signed fixed-point divider: restoring division over a widened dividend,
// one quotient bit per cycle, with rounding, saturation and a pass-through tag.
module fixed_divide_seq #(
    parameter int D_WIDTH   = 32,
    parameter int Q_BITS    = 10,
    parameter int TAG_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [D_WIDTH-1:0]   dividend,
    input  logic [D_WIDTH-1:0]   divisor,
    input  logic                 round_mode,
    input  logic [TAG_WIDTH-1:0] in_tag,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [D_WIDTH-1:0]   quotient,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 div_by_zero,
    output logic                 overflow,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int N     = D_WIDTH + Q_BITS;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [N:0]         MAX_MAG_C = {{(Q_BITS + 2){1'b0}}, {(D_WIDTH - 1){1'b1}}};
    localparam logic [N:0]         MIN_MAG_C = {{(Q_BITS + 1){1'b0}}, 1'b1, {(D_WIDTH - 1){1'b0}}};
    localparam logic [D_WIDTH-1:0] Q_MAX_C   = {1'b0, {(D_WIDTH - 1){1'b1}}};
    localparam logic [D_WIDTH-1:0] Q_MIN_C   = {1'b1, {(D_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // The most negative operand maps to 2^(D_WIDTH-1), which still fits unsigned.
    function automatic logic [D_WIDTH-1:0] abs_val(input logic [D_WIDTH-1:0] v);
        if (v[D_WIDTH-1]) begin
            abs_val = ~v + {{(D_WIDTH - 1){1'b0}}, 1'b1};
        end else begin
            abs_val = v;
        end
    endfunction

    state_t               state_r, state_s;
    logic [N-1:0]         a_r, q_r;
    logic [D_WIDTH-1:0]   b_r;
    logic [D_WIDTH:0]     r_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 sign_r, dsign_r, round_r, zero_r;
    logic [TAG_WIDTH-1:0] tag_r;

    logic                 accept_s, last_step_s, ge_s, round_up_s;
    logic [D_WIDTH:0]     r_shift_s, r_next_s;
    logic [N:0]           mag_s;
    logic [D_WIDTH-1:0]   fix_q_s;
    logic                 fix_dz_s, fix_ov_s;

    assign in_ready    = !reset && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
    assign accept_s    = in_valid && in_ready;
    assign last_step_s = (cnt_r == CNT_W'(N - 1));

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_s = DIV;
                else          state_s = IDLE;
            end
            DIV: begin
                if (last_step_s) state_s = FIX;
                else             state_s = DIV;
            end
            FIX:     state_s = DONE;
            DONE: begin
                if (out_ready) state_s = in_valid ? DIV : IDLE;
                else           state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // One restoring step and the final round/saturate stage
    always_comb begin
        r_shift_s  = {r_r[D_WIDTH-1:0], a_r[N-1]};
        ge_s       = (r_shift_s >= {1'b0, b_r});
        r_next_s   = ge_s ? (r_shift_s - {1'b0, b_r}) : r_shift_s;
        round_up_s = round_r && ({r_r, 1'b0} >= {2'b00, b_r});
        mag_s      = {1'b0, q_r} + {{N{1'b0}}, round_up_s};
        fix_q_s    = {D_WIDTH{1'b0}};
        fix_dz_s   = 1'b0;
        fix_ov_s   = 1'b0;
        if (zero_r) begin
            fix_q_s  = dsign_r ? Q_MIN_C : Q_MAX_C;
            fix_dz_s = 1'b1;
        end else if (!sign_r && (mag_s > MAX_MAG_C)) begin
            fix_q_s  = Q_MAX_C;
            fix_ov_s = 1'b1;
        end else if (sign_r && (mag_s > MIN_MAG_C)) begin
            fix_q_s  = Q_MIN_C;
            fix_ov_s = 1'b1;
        end else begin
            fix_q_s = sign_r ? (~mag_s[D_WIDTH-1:0] + {{(D_WIDTH - 1){1'b0}}, 1'b1})
                             : mag_s[D_WIDTH-1:0];
        end
    end

    // Operand capture, iteration registers and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            a_r         <= {N{1'b0}};
            q_r         <= {N{1'b0}};
            b_r         <= {D_WIDTH{1'b0}};
            r_r         <= {(D_WIDTH + 1){1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            sign_r      <= 1'b0;
            dsign_r     <= 1'b0;
            round_r     <= 1'b0;
            zero_r      <= 1'b0;
            tag_r       <= {TAG_WIDTH{1'b0}};
            quotient    <= {D_WIDTH{1'b0}};
            out_tag     <= {TAG_WIDTH{1'b0}};
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            if (accept_s) begin
                sign_r  <= dividend[D_WIDTH-1] ^ divisor[D_WIDTH-1];
                dsign_r <= dividend[D_WIDTH-1];
                a_r     <= {abs_val(dividend), {Q_BITS{1'b0}}};
                b_r     <= abs_val(divisor);
                round_r <= round_mode;
                zero_r  <= (divisor == {D_WIDTH{1'b0}});
                tag_r   <= in_tag;
                r_r     <= {(D_WIDTH + 1){1'b0}};
                q_r     <= {N{1'b0}};
                cnt_r   <= {CNT_W{1'b0}};
            end else if (state_r == DIV) begin
                r_r   <= r_next_s;
                a_r   <= {a_r[N-2:0], 1'b0};
                q_r   <= {q_r[N-2:0], ge_s};
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (state_r == FIX) begin
                quotient    <= fix_q_s;
                div_by_zero <= fix_dz_s;
                overflow    <= fix_ov_s;
                out_tag     <= tag_r;
                out_valid   <= 1'b1;
            end else if ((state_r == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
